// File: rtl/alu_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_pkg
// Shared definitions for the ALU operand sequencer: FSM state encoding,
// progress thermometer constants and default data/opcode widths.
// ---------------------------------------------------------------------------
package alu_operand_sequencer_pkg;

    localparam int unsigned DEFAULT_BUS_LEN = 8;
    localparam int unsigned DEFAULT_OP_LEN  = 6;
    localparam int unsigned PROG_LEN        = 3;

    typedef enum logic [2:0] {
        S_OPE1   = 3'd0,
        S_OPE2   = 3'd1,
        S_OPCODE = 3'd2,
        S_EXEC   = 3'd3,
        S_SHOW   = 3'd4
    } seqState_t;

    // Thermometer of items captured so far
    localparam logic [PROG_LEN-1:0] PROG_NONE = 3'b000;
    localparam logic [PROG_LEN-1:0] PROG_A    = 3'b001;
    localparam logic [PROG_LEN-1:0] PROG_AB   = 3'b011;
    localparam logic [PROG_LEN-1:0] PROG_ALL  = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button and filters bounce: the debounced level only
// changes after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles. A one-cycle pulse marks each press.
//
// Ports:
//   i_clk    clock
//   reset    asynchronous, active-high reset
//   i_btn    raw, asynchronous button input
//   o_level  debounced button level
//   o_rise   one-cycle pulse, coincident with o_level going high
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             syncOut;
    logic [CNT_W-1:0] stableCnt;

    // Synchroniser, stability counter and level/edge registers
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            syncMeta  <= 1'b0;
            syncOut   <= 1'b0;
            stableCnt <= '0;
            o_level   <= 1'b0;
            o_rise    <= 1'b0;
        end else begin
            syncMeta <= i_btn;
            syncOut  <= syncMeta;
            o_rise   <= 1'b0;
            if (syncOut == o_level) begin
                // Any agreement restarts the stability window
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                stableCnt <= '0;
                o_level   <= ~o_level;
                o_rise    <= ~o_level;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Board front end for the ALU. Debounces ENTER and BACK, then steps through
// capturing operand 1, operand 2 and the opcode from the switches. After the
// opcode is taken, the external ALU result is registered onto the LEDs.
// BACK steps one item backwards; from the result display it returns to the
// opcode so only the operation can be changed.
//
// Ports:
//   i_clk        clock
//   reset        asynchronous, active-high reset
//   i_sw         switch data
//   i_btn_enter  raw ENTER button
//   i_btn_back   raw BACK button
//   o_ope1       operand 1 to ALU
//   o_ope2       operand 2 to ALU
//   o_opcode     opcode to ALU
//   i_result     combinational ALU result
//   o_led        registered result
//   o_progress   thermometer of captured items
//   o_done       one-cycle pulse when a new result is registered
// ---------------------------------------------------------------------------
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned BUS_LEN         = DEFAULT_BUS_LEN,
    parameter int unsigned OP_LEN          = DEFAULT_OP_LEN,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                i_clk,
    input  logic                reset,
    input  logic [BUS_LEN-1:0]  i_sw,
    input  logic                i_btn_enter,
    input  logic                i_btn_back,
    output logic [BUS_LEN-1:0]  o_ope1,
    output logic [BUS_LEN-1:0]  o_ope2,
    output logic [OP_LEN-1:0]   o_opcode,
    input  logic [BUS_LEN-1:0]  i_result,
    output logic [BUS_LEN-1:0]  o_led,
    output logic [PROG_LEN-1:0] o_progress,
    output logic                o_done
);

    seqState_t state;

    logic enterRise;
    logic backRise;
    logic enterPulse;
    logic unusedEnterLevel;
    logic unusedBackLevel;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uEnterDebounce (
        .i_clk  (i_clk),
        .reset  (reset),
        .i_btn  (i_btn_enter),
        .o_level(unusedEnterLevel),
        .o_rise (enterRise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBackDebounce (
        .i_clk  (i_clk),
        .reset  (reset),
        .i_btn  (i_btn_back),
        .o_level(unusedBackLevel),
        .o_rise (backRise)
    );

    // BACK takes priority when both presses land in the same cycle
    assign enterPulse = enterRise & ~backRise;

    // Sequencing FSM with registered outputs
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state      <= S_OPE1;
            o_ope1     <= '0;
            o_ope2     <= '0;
            o_opcode   <= '0;
            o_led      <= '0;
            o_progress <= PROG_NONE;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_OPE1: begin
                    if (enterPulse) begin
                        o_ope1     <= i_sw;
                        o_progress <= PROG_A;
                        state      <= S_OPE2;
                    end
                end
                S_OPE2: begin
                    if (backRise) begin
                        o_progress <= PROG_NONE;
                        state      <= S_OPE1;
                    end else if (enterPulse) begin
                        o_ope2     <= i_sw;
                        o_progress <= PROG_AB;
                        state      <= S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    if (backRise) begin
                        o_progress <= PROG_A;
                        state      <= S_OPE2;
                    end else if (enterPulse) begin
                        o_opcode   <= i_sw[OP_LEN-1:0];
                        o_progress <= PROG_ALL;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable since the opcode capture
                    o_led  <= i_result;
                    o_done <= 1'b1;
                    state  <= S_SHOW;
                end
                S_SHOW: begin
                    if (backRise) begin
                        o_progress <= PROG_AB;
                        state      <= S_OPCODE;
                    end else if (enterPulse) begin
                        o_ope1     <= i_sw;
                        o_progress <= PROG_A;
                        state      <= S_OPE2;
                    end
                end
                default: begin
                    o_progress <= PROG_NONE;
                    state      <= S_OPE1;
                end
            endcase
        end
    end

endmodule
